// File: rtl/bn_relu_skid_fifo.sv
// Elastic BN-to-ReLU stage: DEPTH-entry register FIFO carrying CHANNELS signed lanes plus relu_en.
// Optional macro RELU_FUSE_EN applies ReLU combinationally to the head entry on out_data.
module bn_relu_skid_fifo #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 2,
  localparam int unsigned LEVEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                           in_relu_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           out_relu_en,
  output logic [LEVEL_W-1:0]             level
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned DataW = CHANNELS * DATA_WIDTH;

  logic [DataW-1:0]   data_q [DEPTH];
  logic [DEPTH-1:0]   relu_q;
  logic [PtrW-1:0]    wr_ptr_q;
  logic [PtrW-1:0]    rd_ptr_q;
  logic [LEVEL_W-1:0] count_q;

  logic             push;
  logic             pop;
  logic [DataW-1:0] head_data;

  // Flow control depends on registered occupancy only; no out_ready -> in_ready path.
  assign in_ready  = (count_q != LEVEL_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign level     = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      relu_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
    end else if (flush) begin
      // Storage keeps its contents; only the bookkeeping is cleared.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= in_data;
        relu_q[wr_ptr_q] <= in_relu_en;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data   = data_q[rd_ptr_q];
  assign out_relu_en = relu_q[rd_ptr_q];

`ifdef RELU_FUSE_EN
  always_comb begin
    out_data = head_data;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (out_relu_en && head_data[k*DATA_WIDTH + DATA_WIDTH - 1]) begin
        out_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end
`else
  assign out_data = head_data;
`endif

endmodule

// File: tb/tb_bn_relu_skid_fifo.sv
// Bench for bn_relu_skid_fifo: instance 0 with DEPTH=2, instance 1 with DEPTH=4, queue-level model
// checked every falling edge plus directed literal checks.
module tb_bn_relu_skid_fifo;

`ifdef RELU_FUSE_EN
  localparam bit Fuse = 1'b1;
`else
  localparam bit Fuse = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fl   [2];
  logic        iv   [2];
  logic        ir   [2];
  logic [63:0] idat [2];
  logic        ire  [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [63:0] od   [2];
  logic        ore  [2];
  logic [1:0]  lvl_a;
  logic [2:0]  lvl_b;
  logic [2:0]  lv   [2];

  assign lv[0] = {1'b0, lvl_a};
  assign lv[1] = lvl_b;

  always #5 clk = ~clk;

  bn_relu_skid_fifo #(.CHANNELS(4), .DATA_WIDTH(16), .DEPTH(2)) u_dut_a (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(idat[0]), .in_relu_en(ire[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od[0]), .out_relu_en(ore[0]), .level(lvl_a)
  );

  bn_relu_skid_fifo #(.CHANNELS(4), .DATA_WIDTH(16), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(idat[1]), .in_relu_en(ire[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od[1]), .out_relu_en(ore[1]), .level(lvl_b)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] beat(input int n);
    logic [15:0] l;
    l = 16'(n);
    return {l, l, l, l};
  endfunction

  function automatic logic [63:0] relu_view(input logic [63:0] d, input logic re);
    logic [63:0] r;
    r = d;
    for (int k = 0; k < 4; k++) begin
      if (Fuse && re && $signed(d[k*16 +: 16]) < 0) r[k*16 +: 16] = 16'h0000;
    end
    return r;
  endfunction

  // Model: ring of stored beats per instance, plus occupancy and head/tail positions.
  bit [63:0] m_data [2][4];
  bit        m_re   [2][4];
  int        m_cnt  [2];
  int        m_wp   [2];
  int        m_rp   [2];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 2; i++) begin
        int  d;
        bit  psh;
        bit  pp;
        d = (i == 0) ? 2 : 4;
        if (rst) begin
          m_cnt[i] = 0; m_wp[i] = 0; m_rp[i] = 0;
          for (int e = 0; e < 4; e++) begin
            m_data[i][e] = '0;
            m_re[i][e]   = 1'b0;
          end
        end else if (fl[i]) begin
          m_cnt[i] = 0; m_wp[i] = 0; m_rp[i] = 0;
        end else begin
          psh = iv[i] && (m_cnt[i] < d);
          pp  = ordy[i] && (m_cnt[i] > 0);
          if (psh) begin
            m_data[i][m_wp[i]] = idat[i];
            m_re[i][m_wp[i]]   = ire[i];
            m_wp[i] = (m_wp[i] + 1) % d;
          end
          if (pp) m_rp[i] = (m_rp[i] + 1) % d;
          m_cnt[i] = m_cnt[i] + int'(psh) - int'(pp);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int d;
        d = (i == 0) ? 2 : 4;
        check("model_out_valid", 64'(ov[i]), 64'(m_cnt[i] != 0));
        check("model_in_ready", 64'(ir[i]), 64'(m_cnt[i] != d));
        check("model_level", 64'(lv[i]), 64'(m_cnt[i]));
        check("model_out_data", od[i], relu_view(m_data[i][m_rp[i]], m_re[i][m_rp[i]]));
        check("model_out_relu_en", 64'(ore[i]), 64'(m_re[i][m_rp[i]]));
      end
    end
  end

  int got [$];
  initial begin
    forever begin
      @(negedge clk);
      if (ov[1] && ordy[1]) got.push_back(int'(od[1][15:0]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] lit;
    bit          acc;
    int          tries;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fl[i] = 1'b0; iv[i] = 1'b0; idat[i] = '0; ire[i] = 1'b0; ordy[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset / idle
    check("rst_out_valid", 64'(ov[0]), 64'd0);
    check("rst_in_ready", 64'(ir[0]), 64'd1);
    check("rst_level", 64'(lvl_a), 64'd0);
    check("rst_out_data", od[0], 64'd0);

    // Single beat with negative lanes
    iv[0] = 1'b1; ire[0] = 1'b1; ordy[0] = 1'b1;
    idat[0] = {16'h8000, 16'h7FFF, 16'hFFFE, 16'h0005};
    tick();
    iv[0] = 1'b0; ire[0] = 1'b0;
    lit = Fuse ? {16'h0000, 16'h7FFF, 16'h0000, 16'h0005}
               : {16'h8000, 16'h7FFF, 16'hFFFE, 16'h0005};
    check("single_out_valid", 64'(ov[0]), 64'd1);
    check("single_out_data", od[0], lit);
    check("single_relu_en", 64'(ore[0]), 64'd1);
    check("single_level", 64'(lvl_a), 64'd1);
    tick();
    check("single_drained", 64'(ov[0]), 64'd0);

    // Fill / backpressure on DEPTH=2
    ordy[0] = 1'b0; iv[0] = 1'b1; idat[0] = beat(1);
    tick();
    idat[0] = beat(2);
    tick();
    idat[0] = beat(3);
    check("full_in_ready", 64'(ir[0]), 64'd0);
    check("full_level", 64'(lvl_a), 64'd2);
    check("full_head", od[0], beat(1));
    tick();
    tick();
    check("full_hold_level", 64'(lvl_a), 64'd2);
    check("full_hold_head", od[0], beat(1));
    ordy[0] = 1'b1;
    #1;
    check("full_ready_no_bypass", 64'(ir[0]), 64'd0);
    tick();
    check("bp_level_after_pop", 64'(lvl_a), 64'd1);
    check("bp_head2", od[0], beat(2));
    check("bp_in_ready_back", 64'(ir[0]), 64'd1);
    tick();
    iv[0] = 1'b0;
    check("bp_head3", od[0], beat(3));
    check("bp_level_pushpop", 64'(lvl_a), 64'd1);
    tick();
    check("bp_empty", 64'(ov[0]), 64'd0);

    // Streaming, 20 beats
    iv[0] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      idat[0] = beat(100 + j);
      tick();
      check("stream_level", 64'(lvl_a), 64'd1);
      check("stream_lane0", 64'(od[0][15:0]), 64'(100 + j));
    end
    iv[0] = 1'b0;
    tick();
    check("stream_empty", 64'(ov[0]), 64'd0);

    // Wrap-around on DEPTH=4 with random stalls
    for (int n = 0; n < 7; n++) begin
      iv[1] = 1'b1; idat[1] = beat(200 + n);
      tries = 0;
      do begin
        ordy[1] = ($urandom_range(0, 2) == 0);
        acc = ir[1];
        tick();
        tries++;
        check("wrap_level_le4", 64'(lv[1] <= 3'd4), 64'd1);
      end while (!acc && tries < 50);
      if (!acc) check("wrap_push_timeout", 64'd0, 64'd1);
    end
    iv[1] = 1'b0; ordy[1] = 1'b1;
    tries = 0;
    while (ov[1] && tries < 20) begin
      tick();
      tries++;
    end
    check("wrap_drained", 64'(ov[1]), 64'd0);
    check("wrap_count", 64'(got.size()), 64'd7);
    for (int k = 0; k < 7; k++) begin
      if (k < got.size()) check("wrap_order", 64'(got[k]), 64'(200 + k));
    end

    // Flush at level 2
    ordy[0] = 1'b0; iv[0] = 1'b1; idat[0] = beat(7);
    tick();
    idat[0] = beat(8);
    tick();
    iv[0] = 1'b0;
    check("pre_flush_level", 64'(lvl_a), 64'd2);
    fl[0] = 1'b1; ordy[0] = 1'b1; iv[0] = 1'b1; idat[0] = beat(9);
    tick();
    fl[0] = 1'b0; ordy[0] = 1'b0; iv[0] = 1'b0;
    check("flush_level", 64'(lvl_a), 64'd0);
    check("flush_out_valid", 64'(ov[0]), 64'd0);
    check("flush_in_ready", 64'(ir[0]), 64'd1);
    iv[0] = 1'b1; idat[0] = beat(10);
    tick();
    iv[0] = 1'b0;
    check("post_flush_level", 64'(lvl_a), 64'd1);
    check("post_flush_head", od[0], beat(10));

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(ov[0]), 64'd0);
    check("arst_level", 64'(lvl_a), 64'd0);
    check("arst_out_data", od[0], 64'd0);
    check("arst_in_ready", 64'(ir[0]), 64'd1);
    #2 rst = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
